// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath bundle for the multicycle sequencer
interface multicycle_control_if;
    logic [31:0] IWord;
    logic        mem_ready;
    logic        BEQ;
    logic        BLT;
    logic        PCWrite;
    logic        PCSelect;
    logic        RegWEn;
    logic [2:0]  ImmSel;
    logic        BrUn;
    logic        ASel;
    logic        BSel;
    logic [3:0]  ALUOP;
    logic [1:0]  WBSel;
    logic        MemRW;
    logic [31:0] ir;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] instret;

    // Sequencer side: consumes instruction/flags, drives control lines
    modport master (
        input  IWord, mem_ready, BEQ, BLT,
        output PCWrite, PCSelect, RegWEn, ImmSel, BrUn, ASel, BSel,
               ALUOP, WBSel, MemRW, ir, state, illegal, instret
    );

    // Datapath/memory side
    modport slave (
        output IWord, mem_ready, BEQ, BLT,
        input  PCWrite, PCSelect, RegWEn, ImmSel, BrUn, ASel, BSel,
               ALUOP, WBSel, MemRW, ir, state, illegal, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV32I multicycle control sequencer
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
    } class_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q;
    logic [31:0] instret_q;
    class_t      cls;
    logic [2:0]  funct3;
    logic        alt;
    logic        taken;
    logic        br_ok;

    logic        pc_write, pc_select, reg_wen, mem_rw, br_un, a_sel, b_sel, illegal;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;

    assign funct3 = ir_q[14:12];
    assign alt    = ir_q[30];

    // funct7[5] only turns ADD into SUB for register-register ops
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_ok, input logic a);
        case (f3)
            3'b000:  alu_decode = (sub_ok && a) ? 4'd1 : 4'd0;
            3'b001:  alu_decode = 4'd2;
            3'b010:  alu_decode = 4'd3;
            3'b011:  alu_decode = 4'd4;
            3'b100:  alu_decode = 4'd5;
            3'b101:  alu_decode = a ? 4'd7 : 4'd6;
            3'b110:  alu_decode = 4'd8;
            default: alu_decode = 4'd9;
        endcase
    endfunction

    // Instruction class from the latched opcode
    always_comb begin
        case (ir_q[6:0])
            7'b0110011: cls = C_R;
            7'b0010011: cls = C_IALU;
            7'b0000011: cls = C_LOAD;
            7'b0100011: cls = C_STORE;
            7'b1100011: cls = C_BRANCH;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            7'b0110111: cls = C_LUI;
            7'b0010111: cls = C_AUIPC;
            default:    cls = C_BAD;
        endcase
    end

    // Branch outcome from the comparator flags; funct3 010/011 has no encoding
    always_comb begin
        taken = 1'b0;
        br_ok = 1'b1;
        case (funct3)
            3'b000:          taken = bus.BEQ;
            3'b001:          taken = !bus.BEQ;
            3'b100, 3'b110:  taken = bus.BLT;
            3'b101, 3'b111:  taken = !bus.BLT;
            default:         br_ok = 1'b0;
        endcase
    end

    // State, instruction latch and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= 32'h0000_0013;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && bus.mem_ready)
                ir_q <= bus.IWord;
            if (pc_write)
                instret_q <= instret_q + 32'd1;
        end
    end

    // Next state and control lines; selects are held from EXEC through WB
    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        pc_select = 1'b0;
        reg_wen   = 1'b0;
        mem_rw    = 1'b0;
        br_un     = 1'b0;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        illegal   = 1'b0;
        imm_sel   = 3'd0;
        alu_op    = 4'd0;
        wb_sel    = 2'd0;

        if (state_q == EXEC || state_q == MEM || state_q == WB) begin
            case (cls)
                C_R:      alu_op = alu_decode(funct3, 1'b1, alt);
                C_IALU: begin
                    b_sel  = 1'b1;
                    alu_op = alu_decode(funct3, 1'b0, alt);
                end
                C_LOAD, C_JALR: b_sel = 1'b1;
                C_STORE: begin
                    b_sel   = 1'b1;
                    imm_sel = 3'd1;
                end
                C_LUI: begin
                    b_sel   = 1'b1;
                    imm_sel = 3'd3;
                    alu_op  = 4'd10;
                end
                C_AUIPC: begin
                    a_sel   = 1'b1;
                    b_sel   = 1'b1;
                    imm_sel = 3'd3;
                end
                C_JAL: begin
                    a_sel   = 1'b1;
                    b_sel   = 1'b1;
                    imm_sel = 3'd4;
                end
                C_BRANCH: begin
                    a_sel   = 1'b1;
                    b_sel   = 1'b1;
                    imm_sel = 3'd2;
                    br_un   = funct3[1];
                end
                default: ;
            endcase
        end

        case (state_q)
            FETCH:  if (bus.mem_ready) state_d = DECODE;
            DECODE: state_d = (cls == C_BAD) ? TRAP : EXEC;
            EXEC: begin
                case (cls)
                    C_LOAD, C_STORE: state_d = MEM;
                    C_BRANCH: begin
                        if (br_ok) begin
                            pc_write  = 1'b1;
                            pc_select = taken;
                            state_d   = FETCH;
                        end else begin
                            state_d = TRAP;
                        end
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                if (cls == C_STORE) begin
                    mem_rw = 1'b1;
                    if (bus.mem_ready) begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end
                end else if (bus.mem_ready) begin
                    state_d = WB;
                end
            end
            WB: begin
                reg_wen  = 1'b1;
                pc_write = 1'b1;
                state_d  = FETCH;
                if (cls == C_LOAD) begin
                    wb_sel = 2'd0;
                end else if (cls == C_JAL || cls == C_JALR) begin
                    wb_sel    = 2'd2;
                    pc_select = 1'b1;
                end else begin
                    wb_sel = 2'd1;
                end
            end
            TRAP:    illegal = 1'b1;
            default: state_d = TRAP;
        endcase
    end

    assign bus.PCWrite  = pc_write;
    assign bus.PCSelect = pc_select;
    assign bus.RegWEn   = reg_wen;
    assign bus.MemRW    = mem_rw;
    assign bus.ImmSel   = imm_sel;
    assign bus.BrUn     = br_un;
    assign bus.ASel     = a_sel;
    assign bus.BSel     = b_sel;
    assign bus.ALUOP    = alu_op;
    assign bus.WBSel    = wb_sel;
    assign bus.ir       = ir_q;
    assign bus.state    = state_q;
    assign bus.illegal  = illegal;
    assign bus.instret  = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;
    typedef struct packed {
        logic [2:0]  st;
        logic        pcw;
        logic        rwe;
        logic        mrw;
        logic        pcs;
        logic [2:0]  imm;
        logic        bru;
        logic        asel;
        logic        bsel;
        logic [3:0]  alu;
        logic [1:0]  wbs;
        logic        ill;
        logic [31:0] ir;
        logic [31:0] ret;
    } obs_t;

    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_LW   = 32'h0000_A183;
    localparam logic [31:0] I_BNE  = 32'h0020_9463;
    localparam logic [31:0] I_SW   = 32'h0020_A023;
    localparam logic [31:0] I_SRAI = 32'h4031_5093;
    localparam logic [31:0] I_LUI  = 32'h1234_52B7;
    localparam logic [31:0] I_JAL  = 32'h0000_00EF;
    localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    obs_t q[$];
    logic [31:0] exp_ir;
    logic [31:0] exp_ret;

    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Queue the expected outputs for the current cycle, then advance one cycle
    task automatic cyc(input logic [2:0] st, input logic pcw, input logic rwe, input logic mrw,
                       input logic pcs, input logic [2:0] imm, input logic bru, input logic asel,
                       input logic bsel, input logic [3:0] alu, input logic [1:0] wbs, input logic ill);
        obs_t e;
        if (reset) begin
            exp_ir  = 32'h0000_0013;
            exp_ret = 32'd0;
        end
        e.st = st;   e.pcw = pcw;   e.rwe = rwe;   e.mrw = mrw;
        e.pcs = pcs; e.imm = imm;   e.bru = bru;   e.asel = asel;
        e.bsel = bsel; e.alu = alu; e.wbs = wbs;   e.ill = ill;
        e.ir = exp_ir; e.ret = exp_ret;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!reset) begin
            if (pcw) exp_ret = exp_ret + 32'd1;
            if (st == 3'd0 && bus.mem_ready) exp_ir = bus.IWord;
        end
    endtask

    task automatic idle(input logic [2:0] st);
        cyc(st, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, 2'd0, 0);
    endtask

    // Monitor: compare one queued expectation against the DUT each cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            obs_t e, a;
            e = q.pop_front();
            a.st = bus.state;     a.pcw = bus.PCWrite; a.rwe = bus.RegWEn; a.mrw = bus.MemRW;
            a.pcs = bus.PCSelect; a.imm = bus.ImmSel;  a.bru = bus.BrUn;   a.asel = bus.ASel;
            a.bsel = bus.BSel;    a.alu = bus.ALUOP;   a.wbs = bus.WBSel;  a.ill = bus.illegal;
            a.ir = bus.ir;        a.ret = bus.instret;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle%0d got st=%0d pcw=%b rwe=%b mrw=%b pcs=%b imm=%0d bru=%b as=%b bs=%b alu=%0d wb=%0d ill=%b ir=%h ret=%0d want st=%0d pcw=%b rwe=%b mrw=%b pcs=%b imm=%0d bru=%b as=%b bs=%b alu=%0d wb=%0d ill=%b ir=%h ret=%0d",
                         total, a.st, a.pcw, a.rwe, a.mrw, a.pcs, a.imm, a.bru, a.asel, a.bsel, a.alu, a.wbs, a.ill, a.ir, a.ret,
                         e.st, e.pcw, e.rwe, e.mrw, e.pcs, e.imm, e.bru, e.asel, e.bsel, e.alu, e.wbs, e.ill, e.ir, e.ret);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.IWord = 32'd0;
        bus.mem_ready = 1'b0;
        bus.BEQ = 1'b0;
        bus.BLT = 1'b0;
        exp_ir = 32'h0000_0013;
        exp_ret = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        idle(0);

        // ADD: 4 cycles
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.IWord = I_ADD;
        idle(0); idle(1);
        cyc(2, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, 2'd0, 0);
        cyc(4, 1, 1, 0, 0, 3'd0, 0, 0, 0, 4'd0, 2'd1, 0);

        // LW with two wait cycles in MEM: 7 cycles
        bus.IWord = I_LW;
        idle(0); idle(1);
        cyc(2, 0, 0, 0, 0, 3'd0, 0, 0, 1, 4'd0, 2'd0, 0);
        bus.mem_ready = 1'b0;
        cyc(3, 0, 0, 0, 0, 3'd0, 0, 0, 1, 4'd0, 2'd0, 0);
        cyc(3, 0, 0, 0, 0, 3'd0, 0, 0, 1, 4'd0, 2'd0, 0);
        bus.mem_ready = 1'b1;
        cyc(3, 0, 0, 0, 0, 3'd0, 0, 0, 1, 4'd0, 2'd0, 0);
        cyc(4, 1, 1, 0, 0, 3'd0, 0, 0, 1, 4'd0, 2'd0, 0);

        // BNE not taken then taken: 3 cycles each
        bus.IWord = I_BNE;
        bus.BEQ = 1'b1;
        idle(0); idle(1);
        cyc(2, 1, 0, 0, 0, 3'd2, 0, 1, 1, 4'd0, 2'd0, 0);
        bus.BEQ = 1'b0;
        idle(0); idle(1);
        cyc(2, 1, 0, 0, 1, 3'd2, 0, 1, 1, 4'd0, 2'd0, 0);

        // SW with one wait cycle in MEM
        bus.IWord = I_SW;
        idle(0); idle(1);
        cyc(2, 0, 0, 0, 0, 3'd1, 0, 0, 1, 4'd0, 2'd0, 0);
        bus.mem_ready = 1'b0;
        cyc(3, 0, 0, 1, 0, 3'd1, 0, 0, 1, 4'd0, 2'd0, 0);
        bus.mem_ready = 1'b1;
        cyc(3, 1, 0, 1, 0, 3'd1, 0, 0, 1, 4'd0, 2'd0, 0);

        // SRAI after a FETCH wait cycle
        bus.IWord = I_SRAI;
        bus.mem_ready = 1'b0;
        idle(0);
        bus.mem_ready = 1'b1;
        idle(0); idle(1);
        cyc(2, 0, 0, 0, 0, 3'd0, 0, 0, 1, 4'd7, 2'd0, 0);
        cyc(4, 1, 1, 0, 0, 3'd0, 0, 0, 1, 4'd7, 2'd1, 0);

        // LUI: PASSB with U immediate
        bus.IWord = I_LUI;
        idle(0); idle(1);
        cyc(2, 0, 0, 0, 0, 3'd3, 0, 0, 1, 4'd10, 2'd0, 0);
        cyc(4, 1, 1, 0, 0, 3'd3, 0, 0, 1, 4'd10, 2'd1, 0);

        // JAL: link write and ALU-target PC
        bus.IWord = I_JAL;
        idle(0); idle(1);
        cyc(2, 0, 0, 0, 0, 3'd4, 0, 1, 1, 4'd0, 2'd0, 0);
        cyc(4, 1, 1, 0, 1, 3'd4, 0, 1, 1, 4'd0, 2'd2, 0);

        // Reset asserted mid-cycle during EXEC of an ADD
        bus.IWord = I_ADD;
        idle(0); idle(1);
        reset = 1'b1;
        idle(0);
        idle(0);
        reset = 1'b0;

        // Illegal opcode traps and stays there
        bus.IWord = I_BAD;
        idle(0); idle(1);
        cyc(5, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, 2'd0, 1);
        bus.IWord = I_ADD;
        cyc(5, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, 2'd0, 1);
        cyc(5, 0, 0, 0, 0, 3'd0, 0, 0, 0, 4'd0, 2'd0, 1);
        reset = 1'b1;
        idle(0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
